alu_operand_entry: RTL and testbench



---
 rtl/alu_entry_pkg.sv | 29 ++
 rtl/alu_operand_entry_button_debounce.sv | 46 ++++
 rtl/alu_operand_entry.sv | 169 ++++++++++++++++
 tb/tb_alu_operand_entry.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_entry_pkg.sv
// Shared definitions for the ALU operand entry front end: stage encoding,
// operand/opcode widths and the number of nibbles making up each field.
package alu_entry_pkg;

    localparam int OPERAND_W  = 16;
    localparam int OPCODE_W   = 8;
    localparam int A_NIBBLES  = 4;
    localparam int B_NIBBLES  = 4;
    localparam int OP_NIBBLES = 2;
    localparam int NIB_CNT_W  = 3;

    // Stage encoding is visible on the LEDs, so the values are fixed.
    typedef enum logic [2:0] {
        ST_ENTER_A     = 3'd0,
        ST_ENTER_B     = 3'd1,
        ST_ENTER_OP    = 3'd2,
        ST_ENTER_CARRY = 3'd3,
        ST_VALID       = 3'd4
    } stage_t;

    // Append a nibble at the least-significant end; entry is MSB-nibble first.
    function automatic logic [OPERAND_W-1:0] shift_in(
        input logic [OPERAND_W-1:0] cur,
        input logic [3:0]           nib
    );
        return {cur[OPERAND_W-5:0], nib};
    endfunction

endpackage

// File: rtl/alu_operand_entry_button_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter, debounced
// level and a single-cycle press pulse on the debounced rising edge.
// The pulse lands DEBOUNCE_CYCLES+2 cycles after the first clock edge that
// samples the raw input high.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize, count disagreement cycles, flip level once stable, detect rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/alu_operand_entry.sv
// Operand writer for the ALU: collects A, B and the opcode one nibble at a
// time (MSB nibble first) from debounced buttons, then offers the operation
// with a valid/ready handshake, holding a/b/opcode/carry_in until accepted.
// Build option CARRY_ENTRY_EN adds a carry entry step after the opcode;
// without it carry_in is tied to 0.
//
// state          | meaning
// ---------------+-----------------------------------------------
// ST_ENTER_A     | collecting 4 nibbles of operand A
// ST_ENTER_B     | collecting 4 nibbles of operand B
// ST_ENTER_OP    | collecting 2 nibbles of the opcode
// ST_ENTER_CARRY | one press captures sw[0] as carry (option only)
// ST_VALID       | operation offered, waiting for op_ready
module alu_operand_entry
    import alu_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           sw,
    input  logic                 btn_enter,
    input  logic                 btn_clear,
    output logic [OPERAND_W-1:0] a,
    output logic [OPERAND_W-1:0] b,
    output logic [OPCODE_W-1:0]  opcode,
    output logic                 carry_in,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [2:0]           stage,
    output logic [OPERAND_W-1:0] shadow
);

    stage_t                 state;
    logic [NIB_CNT_W-1:0]   nib_cnt;
    logic                   enter_p;
    logic                   clear_p;
    logic                   field_last;
    logic [OPERAND_W-1:0]   nib_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_enter),
        .press(enter_p)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_clear),
        .press(clear_p)
    );

    assign nib_next = shift_in(shadow, sw);
    assign stage    = state;

    // Flag the press that completes the field being entered in this state.
    always_comb begin
        field_last = 1'b0;
        case (state)
            ST_ENTER_A:  field_last = (nib_cnt == NIB_CNT_W'(A_NIBBLES - 1));
            ST_ENTER_B:  field_last = (nib_cnt == NIB_CNT_W'(B_NIBBLES - 1));
            ST_ENTER_OP: field_last = (nib_cnt == NIB_CNT_W'(OP_NIBBLES - 1));
            default:     field_last = 1'b0;
        endcase
    end

`ifndef CARRY_ENTRY_EN
    assign carry_in = 1'b0;
`endif

    // Entry sequencer: clear has priority over enter and over the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ENTER_A;
            nib_cnt  <= '0;
            shadow   <= '0;
            a        <= '0;
            b        <= '0;
            opcode   <= '0;
            op_valid <= 1'b0;
`ifdef CARRY_ENTRY_EN
            carry_in <= 1'b0;
`endif
        end else if (clear_p) begin
            state    <= ST_ENTER_A;
            nib_cnt  <= '0;
            shadow   <= '0;
            op_valid <= 1'b0;
        end else begin
            case (state)
                ST_ENTER_A: begin
                    if (enter_p) begin
                        if (field_last) begin
                            a       <= nib_next;
                            shadow  <= '0;
                            nib_cnt <= '0;
                            state   <= ST_ENTER_B;
                        end else begin
                            shadow  <= nib_next;
                            nib_cnt <= nib_cnt + NIB_CNT_W'(1);
                        end
                    end
                end
                ST_ENTER_B: begin
                    if (enter_p) begin
                        if (field_last) begin
                            b       <= nib_next;
                            shadow  <= '0;
                            nib_cnt <= '0;
                            state   <= ST_ENTER_OP;
                        end else begin
                            shadow  <= nib_next;
                            nib_cnt <= nib_cnt + NIB_CNT_W'(1);
                        end
                    end
                end
                ST_ENTER_OP: begin
                    if (enter_p) begin
                        if (field_last) begin
                            opcode  <= nib_next[OPCODE_W-1:0];
                            shadow  <= '0;
                            nib_cnt <= '0;
`ifdef CARRY_ENTRY_EN
                            state   <= ST_ENTER_CARRY;
`else
                            state    <= ST_VALID;
                            op_valid <= 1'b1;
`endif
                        end else begin
                            shadow  <= nib_next;
                            nib_cnt <= nib_cnt + NIB_CNT_W'(1);
                        end
                    end
                end
`ifdef CARRY_ENTRY_EN
                ST_ENTER_CARRY: begin
                    if (enter_p) begin
                        carry_in <= sw[0];
                        state    <= ST_VALID;
                        op_valid <= 1'b1;
                    end
                end
`endif
                ST_VALID: begin
                    if (op_valid && op_ready) begin
                        op_valid <= 1'b0;
                        state    <= ST_ENTER_A;
                    end
                end
                default: begin
                    state    <= ST_ENTER_A;
                    nib_cnt  <= '0;
                    shadow   <= '0;
                    op_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_entry.sv
// Self-checking bench for alu_operand_entry with a short debounce window.
// The reference model tracks entry progress as plain arithmetic on
// nibble counts and field values.
module tb_alu_operand_entry;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  opcode;
    logic        carry_in;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  stage;
    logic [15:0] shadow;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [15:0] m_a, m_b, m_shadow;
    logic [7:0]  m_op;
    logic        m_carry, m_valid;
    logic [2:0]  m_stage;
    int          m_cnt;

`ifdef CARRY_ENTRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    alu_operand_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .carry_in (carry_in),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .stage    (stage),
        .shadow   (shadow)
    );

    always #5 clk = ~clk;

    wire [60:0] obs_vec = {a, b, opcode, carry_in, op_valid, stage, shadow};

    function automatic logic [60:0] exp_vec();
        return {m_a, m_b, m_op, m_carry, m_valid, m_stage, m_shadow};
    endfunction

    function automatic int field_len(input logic [2:0] st);
        case (st)
            3'd0:    return 4;
            3'd1:    return 4;
            3'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_carry = 0; m_valid = 0;
        m_stage = 0; m_shadow = 0; m_cnt = 0;
    endtask

    task automatic model_enter(input logic [3:0] nib);
        int val;
        if (m_stage == 3'd4) return;
        if (m_stage == 3'd3) begin
            m_carry = nib[0];
            m_stage = 3'd4;
            m_valid = 1'b1;
            return;
        end
        m_cnt = m_cnt + 1;
        val = (int'(m_shadow) * 16 + int'(nib)) % 65536;
        if (m_cnt == field_len(m_stage)) begin
            if (m_stage == 3'd0) m_a = 16'(val);
            else if (m_stage == 3'd1) m_b = 16'(val);
            else m_op = 8'(val % 256);
            m_shadow = 0;
            m_cnt = 0;
            if (m_stage == 3'd2) begin
                m_stage = CARRY_EN ? 3'd3 : 3'd4;
                if (m_stage == 3'd4) m_valid = 1'b1;
            end else begin
                m_stage = m_stage + 3'd1;
            end
        end else begin
            m_shadow = 16'(val);
        end
    endtask

    task automatic model_clear();
        m_stage = 0; m_shadow = 0; m_cnt = 0; m_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [3:0] nib);
        sw = nib;
        btn_enter = 1'b1;
        repeat (10) tick();
        btn_enter = 1'b0;
        repeat (10) tick();
        model_enter(nib);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        repeat (10) tick();
        btn_clear = 1'b0;
        repeat (10) tick();
        model_clear();
    endtask

    task automatic test_reset();
        model_reset();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_values obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_debounce();
        sw = 4'h7;
        btn_enter = 1'b1;
        repeat (DB + 3) tick();
        checks++;
        if (shadow !== 16'h0000) begin
            failures++;
            $display("FAIL debounce_early shadow=%h exp=0000", shadow);
        end
        tick();
        model_enter(4'h7);
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL debounce_on_time obs=%h exp=%h", obs_vec, exp_vec());
        end
        repeat (20) tick();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL debounce_single_pulse obs=%h exp=%h", obs_vec, exp_vec());
        end
        btn_enter = 1'b0;
        repeat (10) tick();
        sw = 4'h9;
        btn_enter = 1'b1;
        repeat (2) tick();
        btn_enter = 1'b0;
        repeat (15) tick();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL debounce_glitch obs=%h exp=%h", obs_vec, exp_vec());
        end
        press_clear();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL debounce_clear obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_full_entry();
        logic [3:0] nibs [10];
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h5};
        for (int i = 0; i < 9; i++) begin
            press_enter(nibs[i]);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL full_entry_nibble%0d obs=%h exp=%h", i, obs_vec, exp_vec());
            end
        end
        sw = nibs[9];
        btn_enter = 1'b1;
        repeat (DB + 3) tick();
        checks++;
        if (op_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_entry_valid_early op_valid=%b exp=0", op_valid);
        end
        tick();
        model_enter(nibs[9]);
        checks++;
        if (CARRY_EN ? (stage !== 3'd3) : (op_valid !== 1'b1)) begin
            failures++;
            $display("FAIL full_entry_valid_next op_valid=%b stage=%0d", op_valid, stage);
        end
        btn_enter = 1'b0;
        repeat (10) tick();
        checks++;
        if (obs_vec !== exp_vec() || a !== 16'h1234 || b !== 16'hABCD || opcode !== 8'h05) begin
            failures++;
            $display("FAIL full_entry_values obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

`ifdef CARRY_ENTRY_EN
    task automatic test_carry();
        press_enter(4'b0001);
        checks++;
        if (obs_vec !== exp_vec() || carry_in !== 1'b1 || op_valid !== 1'b1) begin
            failures++;
            $display("FAIL carry_entry obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask
`endif

    task automatic test_hold();
        op_ready = 1'b0;
        repeat (20) tick();
        press_enter(4'h3);
        press_enter(4'h6);
        checks++;
        if (obs_vec !== exp_vec() || op_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable obs=%h exp=%h", obs_vec, exp_vec());
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        m_valid = 0;
        m_stage = 0;
        checks++;
        if (obs_vec !== exp_vec() || stage !== 3'd0) begin
            failures++;
            $display("FAIL hold_accept obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_clear_mid_b();
        logic [15:0] old_b;
        old_b = m_b;
        for (int i = 0; i < 4; i++) press_enter(4'($urandom_range(0, 15)));
        press_enter(4'($urandom_range(0, 15)));
        press_enter(4'($urandom_range(0, 15)));
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL clear_mid_b_before obs=%h exp=%h", obs_vec, exp_vec());
        end
        press_clear();
        checks++;
        if (obs_vec !== exp_vec() || b !== old_b || shadow !== 16'h0) begin
            failures++;
            $display("FAIL clear_mid_b_after obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_same_cycle();
        press_enter(4'hE);
        sw = 4'hF;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (10) tick();
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) tick();
        model_clear();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL same_cycle_clear_wins obs=%h exp=%h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 4; i++) press_enter(4'($urandom_range(0, 15)));
        checks++;
        if (obs_vec !== exp_vec() || stage !== 3'd1) begin
            failures++;
            $display("FAIL same_cycle_count_zero obs=%h exp=%h", obs_vec, exp_vec());
        end
        press_clear();
    endtask

    task automatic test_random_ops();
        int n;
        for (int it = 0; it < 3; it++) begin
            n = CARRY_EN ? 11 : 10;
            for (int k = 0; k < n; k++) begin
                op_ready = (k < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
                press_enter(4'($urandom_range(0, 15)));
            end
            op_ready = 1'b0;
            checks++;
            if (obs_vec !== exp_vec() || op_valid !== 1'b1) begin
                failures++;
                $display("FAIL random_op%0d obs=%h exp=%h", it, obs_vec, exp_vec());
            end
            if (it == 2) begin
                press_clear();
            end else begin
                op_ready = 1'b1;
                tick();
                op_ready = 1'b0;
                m_valid = 0;
                m_stage = 0;
            end
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_release%0d obs=%h exp=%h", it, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        press_enter(4'h8);
        press_enter(4'h2);
        sw = 4'h4;
        btn_enter = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset obs=%h exp=%h", obs_vec, exp_vec());
        end
        btn_enter = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        press_enter(4'hC);
        checks++;
        if (obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL after_reset_entry obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw = 4'h0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        op_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_debounce();
        test_full_entry();
`ifdef CARRY_ENTRY_EN
        test_carry();
`endif
        test_hold();
        test_clear_mid_b();
        test_same_cycle();
        test_random_ops();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
